// File: rtl/pid_pkg.sv
// Shared types and defaults for the PID actuator-side PWM driver.
package pid_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int SLEW_MAX_DEF = 4;
    localparam int DEADTIME_DEF = 2;

    typedef enum logic [2:0] {
        OFF,
        HI,
        DT_FALL,
        LO,
        DT_RISE
    } dt_state_e;

endpackage

// File: rtl/pid_deadtime_gen.sv
// Complementary gate driver: turns the raw PWM level into a hi/lo pair
// separated by DEADTIME clocks of both-low on every transition.
module pid_deadtime_gen
    import pid_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic en,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam int              DT_W    = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DT_W-1:0] DT_LAST = DT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);
    localparam bit              HAS_DT  = (DEADTIME > 0);

    dt_state_e       state;
    dt_state_e       state_next;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] dt_cnt_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        dt_cnt_next = '0;
        if (!en) begin
            state_next = OFF;
        end else begin
            case (state)
                OFF:     state_next = raw ? (HAS_DT ? DT_RISE : HI) : LO;
                HI:      if (!raw) state_next = HAS_DT ? DT_FALL : LO;
                LO:      if (raw)  state_next = HAS_DT ? DT_RISE : HI;
                DT_FALL,
                DT_RISE: begin
                    // Decision is taken on raw at expiry, so a short raw pulse never reaches the gate.
                    if (dt_cnt == DT_LAST) begin
                        state_next = raw ? HI : LO;
                    end else begin
                        dt_cnt_next = dt_cnt + DT_W'(1);
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= OFF;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            state  <= state_next;
            dt_cnt <= dt_cnt_next;
            pwm_hi <= (state_next == HI);
            pwm_lo <= (state_next == LO);
        end
    end

endmodule

// File: rtl/pid_pwm_driver.sv
// PID actuator driver: command shadow register, slew-limited duty update at
// period boundaries, edge-aligned PWM counter and dead-time gate pair.
module pid_pwm_driver
    import pid_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = 1,
    parameter int SLEW_MAX = SLEW_MAX_DEF,
    parameter int DEADTIME = DEADTIME_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic [WIDTH-1:0] duty_q
);

    localparam int               W1       = WIDTH + 1;
    localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;
    localparam logic [WIDTH:0]   SLEW     = W1'(SLEW_MAX);
    localparam logic [WIDTH-1:0] SLEW_N   = WIDTH'(SLEW_MAX);

    logic [PS_W-1:0]  prescaler;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic             shadow_full;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_next;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH:0]   diff_up;
    logic [WIDTH:0]   diff_dn;
    logic             en_q;
    logic             tick;
    logic             boundary;
    logic             take;
    logic             raw;

    assign cmd_ready = !shadow_full && !rst;
    assign take      = cmd_valid && cmd_ready;
    assign tick      = en && (prescaler == PS_LAST);
    // The first enabled cycle restarts the period and behaves as a boundary.
    assign boundary  = en && (!en_q || (tick && (cnt == CNT_LAST)));
    assign raw       = (cnt < duty_q);

    always_comb begin
        target_next = shadow_full ? shadow : target;
        diff_up     = {1'b0, target_next} - {1'b0, duty_q};
        diff_dn     = {1'b0, duty_q} - {1'b0, target_next};
        duty_next   = target_next;
        if (target_next > duty_q) begin
            if (diff_up > SLEW) duty_next = duty_q + SLEW_N;
        end else if (diff_dn > SLEW) begin
            duty_next = duty_q - SLEW_N;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            cnt          <= '0;
            shadow_full  <= 1'b0;
            target       <= '0;
            duty_q       <= '0;
            period_start <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            en_q         <= en;
            period_start <= boundary;

            if (!en || !en_q) begin
                prescaler <= '0;
                cnt       <= '0;
            end else if (tick) begin
                prescaler <= '0;
                cnt       <= cnt + WIDTH'(1);
            end else begin
                prescaler <= prescaler + PS_W'(1);
            end

            if (take) begin
                shadow_full <= 1'b1;
            end else if (boundary && shadow_full) begin
                shadow_full <= 1'b0;
            end

            if (boundary) begin
                target <= target_next;
                duty_q <= duty_next;
            end
        end
    end

    // NOTE: the shadow data register is not reset; shadow_full alone decides whether it is valid.
    always_ff @(posedge clk) begin
        if (take) shadow <= cmd_data;
    end

    pid_deadtime_gen #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw),
        .en     (en),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Self-checking bench for pid_pwm_driver: duty values expected at each period
// boundary are queued when commands are driven and popped at period_start.
module tb_pid_pwm_driver;

    localparam int WIDTH    = 8;
    localparam int PRESCALE = 1;
    localparam int SLEW_MAX = 4;
    localparam int DEADTIME = 2;
    localparam int PERIOD   = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cmd_valid;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;
    logic             pwm_hi;
    logic             pwm_lo;
    logic             period_start;
    logic [WIDTH-1:0] duty_q;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] sb_exp;

    always #5 clk = ~clk;

    pid_pwm_driver #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE),
        .SLEW_MAX (SLEW_MAX),
        .DEADTIME (DEADTIME)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .duty_q       (duty_q)
    );

    // Scoreboard: applied duty at every expected period boundary.
    always @(negedge clk) begin
        if (!rst && period_start && exp_q.size() != 0) begin
            sb_exp = exp_q.pop_front();
            n_checks++;
            if (duty_q !== sb_exp) begin
                n_fail++;
                $display("FAIL sb_duty: duty_q=%h expected %h at %0t", duty_q, sb_exp, $time);
            end
        end
    end

    // Gate pair must never be on together.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (pwm_hi && pwm_lo) begin
                n_fail++;
                $display("FAIL overlap: pwm_hi=%b pwm_lo=%b expected not both 1 at %0t", pwm_hi, pwm_lo, $time);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [WIDTH-1:0] d);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout: cmd_ready=%b expected 1 for data %h", cmd_ready, d);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_period_duty(input logic [WIDTH-1:0] v, input int budget, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(period_start === 1'b1 && duty_q === v) && k < budget);
        n_checks++;
        if (!(period_start === 1'b1 && duty_q === v)) begin
            n_fail++;
            $display("FAIL %s: duty_q=%h period_start=%b expected boundary with duty %h within %0d clocks",
                     name, duty_q, period_start, v, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== 1'b0 || pwm_hi !== 1'b0 || pwm_lo !== 1'b0 ||
                duty_q !== 8'h00 || period_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: ready=%b hi=%b lo=%b duty=%h ps=%b expected 0 0 0 00 0",
                         cmd_ready, pwm_hi, pwm_lo, duty_q, period_start);
            end
        end
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || pwm_hi !== 1'b0 || pwm_lo !== 1'b0 || duty_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b hi=%b lo=%b duty=%h expected 1 0 0 00",
                     cmd_ready, pwm_hi, pwm_lo, duty_q);
        end
    endtask

    task automatic test_slew();
        int hi = 0;
        int lo = 0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h10);
        en = 1'b1;
        send(8'h10);
        wait_period_duty(8'h10, 6 * PERIOD, "slew_reach");
        for (int i = 0; i < PERIOD; i++) begin
            if (i != 0) @(negedge clk);
            if (pwm_hi) hi++;
            if (pwm_lo) lo++;
        end
        n_checks++;
        if (hi != 14) begin
            n_fail++;
            $display("FAIL slew_hi_width: %0d clocks expected 14", hi);
        end
        n_checks++;
        if (lo != 238) begin
            n_fail++;
            $display("FAIL slew_lo_width: %0d clocks expected 238", lo);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL slew_sb_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h14);
        exp_q.push_back(8'h18);
        exp_q.push_back(8'h1C);
        send(8'h20);
        cmd_valid = 1'b1;
        cmd_data  = 8'h40;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low: cmd_ready=%b expected 0 with shadow full", cmd_ready);
        end
        while (cmd_ready !== 1'b1 && k < 2 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: ready=%b period_start=%b expected both 1 right after boundary",
                     cmd_ready, period_start);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 4 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_sb_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_deadtime();
        logic prev_hi = 1'b0;
        logic prev_lo = 1'b0;
        logic fell    = 1'b0;
        logic hi_full = 1'b0;
        logic lo_full = 1'b0;
        int   gap     = 0;
        int   run_hi  = 0;
        int   run_lo  = 0;
        send(8'h80);
        wait_period_duty(8'h80, 40 * PERIOD, "dt_reach");
        prev_hi = pwm_hi;
        prev_lo = pwm_lo;
        for (int i = 0; i < 10 * PERIOD; i++) begin
            @(negedge clk);
            if (!pwm_hi && !pwm_lo) gap++;
            if ((pwm_hi && !prev_hi) || (pwm_lo && !prev_lo)) begin
                if (fell) begin
                    n_checks++;
                    if (gap != DEADTIME) begin
                        n_fail++;
                        $display("FAIL dt_gap: %0d both-low clocks expected %0d at %0t", gap, DEADTIME, $time);
                    end
                end
                if (pwm_hi) begin hi_full = 1'b1; run_hi = 0; end
                if (pwm_lo) begin lo_full = 1'b1; run_lo = 0; end
            end
            if (pwm_hi) run_hi++;
            if (pwm_lo) run_lo++;
            if (!pwm_hi && prev_hi) begin
                fell = 1'b1; gap = 1;
                if (hi_full) begin
                    n_checks++;
                    if (run_hi != 126) begin
                        n_fail++;
                        $display("FAIL dt_hi_width: %0d clocks expected 126", run_hi);
                    end
                end
            end
            if (!pwm_lo && prev_lo) begin
                fell = 1'b1; gap = 1;
                if (lo_full) begin
                    n_checks++;
                    if (run_lo != 126) begin
                        n_fail++;
                        $display("FAIL dt_lo_width: %0d clocks expected 126", run_lo);
                    end
                end
            end
            prev_hi = pwm_hi;
            prev_lo = pwm_lo;
        end
        n_checks++;
        if (duty_q !== 8'h80) begin
            n_fail++;
            $display("FAIL dt_duty_hold: duty_q=%h expected 80", duty_q);
        end
    endtask

    task automatic test_extremes();
        int hi = 0;
        int lo = 0;
        int both = 0;
        send(8'h00);
        wait_period_duty(8'h00, 40 * PERIOD, "ext0_reach");
        wait_period_duty(8'h00, PERIOD + 8, "ext0_next");
        for (int i = 0; i < PERIOD; i++) begin
            if (i != 0) @(negedge clk);
            if (pwm_hi) hi++;
            if (pwm_lo) lo++;
        end
        n_checks++;
        if (hi != 0 || lo != PERIOD) begin
            n_fail++;
            $display("FAIL ext0: hi=%0d lo=%0d clocks expected 0 and %0d", hi, lo, PERIOD);
        end
        send(8'hFF);
        wait_period_duty(8'hFF, 70 * PERIOD, "extff_reach");
        wait_period_duty(8'hFF, PERIOD + 8, "extff_next");
        hi = 0;
        lo = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i != 0) @(negedge clk);
            if (pwm_hi) hi++;
            if (pwm_lo) lo++;
            if (!pwm_hi && !pwm_lo) both++;
        end
        n_checks++;
        if (lo != 0) begin
            n_fail++;
            $display("FAIL extff_lo: pwm_lo high %0d clocks expected 0", lo);
        end
        n_checks++;
        if (both < DEADTIME || both > 2 * DEADTIME || hi == 0) begin
            n_fail++;
            $display("FAIL extff_gap: both-low %0d clocks, hi %0d, expected gap %0d..%0d with hi active",
                     both, hi, DEADTIME, 2 * DEADTIME);
        end
    endtask

    task automatic test_en_reset();
        wait_period_duty(8'hFF, PERIOD + 8, "en_sync");
        repeat (8'h57) @(negedge clk);
        n_checks++;
        if (pwm_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL en_pre: pwm_hi=%b expected 1 at cnt 57", pwm_hi);
        end
        en = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0 || period_start !== 1'b0 || duty_q !== 8'hFF) begin
                n_fail++;
                $display("FAIL en_off: hi=%b lo=%b ps=%b duty=%h expected 0 0 0 ff",
                         pwm_hi, pwm_lo, period_start, duty_q);
            end
        end
        send(8'h30);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL en_handshake: cmd_ready=%b expected 0 after transfer while disabled", cmd_ready);
        end
        exp_q.push_back(8'hFB);
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (period_start !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL en_restart: period_start=%b cmd_ready=%b expected 1 1 on second enabled cycle",
                     period_start, cmd_ready);
        end
        repeat (5) @(negedge clk);
        send(8'h99);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_shadow_full: cmd_ready=%b expected 0", cmd_ready);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== 1'b0 || pwm_hi !== 1'b0 || pwm_lo !== 1'b0 ||
                duty_q !== 8'h00 || period_start !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid: ready=%b hi=%b lo=%b duty=%h ps=%b expected 0 0 0 00 0",
                         cmd_ready, pwm_hi, pwm_lo, duty_q, period_start);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || duty_q !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_discard: cmd_ready=%b duty_q=%h expected 1 00", cmd_ready, duty_q);
        end
        wait_period_duty(8'h00, PERIOD + 8, "rst_duty_stays0");
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_sb_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        test_reset();
        test_slew();
        test_back_to_back();
        test_deadtime();
        test_extremes();
        test_en_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
